// File: rtl/max_pool_2x2_if.sv
// Streaming pixel bus between the convolution stage and the 2x2 max-pool stage.
// The master drives pixels in; the slave (the pooling block) drives pooled results back.
interface max_pool_2x2_if #(
    parameter int WORD_SIZE = 8
);
    logic                 in_valid;
    logic [WORD_SIZE-1:0] in_pixel;
    logic                 out_valid;
    logic [WORD_SIZE-1:0] out_pixel;
    logic                 frame_done;

    modport master (
        output in_valid,
        output in_pixel,
        input  out_valid,
        input  out_pixel,
        input  frame_done
    );

    modport slave (
        input  in_valid,
        input  in_pixel,
        output out_valid,
        output out_pixel,
        output frame_done
    );
endinterface

// File: rtl/max_pool_2x2.sv
// 2x2 max pooling over a raster-order pixel stream.
// Even rows fold each horizontal pixel pair into a half-width line buffer.
// Odd rows combine their own pixel pair with the stored value and emit one pooled pixel per 2x2 block.
module max_pool_2x2 #(
    parameter int WORD_SIZE = 8,
    parameter int ROW_SIZE  = 540,
    parameter int NUM_ROWS  = 540
) (
    input  logic           clk,
    input  logic           rst_n,
    max_pool_2x2_if.slave  bus
);

    localparam int CW       = $clog2(ROW_SIZE);
    localparam int RW       = $clog2(NUM_ROWS);
    localparam int LB_DEPTH = ROW_SIZE / 2;
    localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [WORD_SIZE-1:0] pair_reg;
    logic [WORD_SIZE-1:0] line_buf [LB_DEPTH];

    logic [LBW-1:0]       lb_idx;
    logic [WORD_SIZE-1:0] lb_rd;
    logic [WORD_SIZE-1:0] pair_max;
    logic [WORD_SIZE-1:0] quad_max;
    logic                 col_last;
    logic                 row_last;
    logic                 lb_we;
    logic                 out_load;
    logic                 last_out;

    // Position decode and the unsigned max tree for the current block.
    always_comb begin
        col_last = (col == COL_LAST);
        row_last = (row == ROW_LAST);
        lb_idx   = LBW'(col >> 1);
        lb_rd    = line_buf[lb_idx];
        pair_max = (bus.in_pixel > pair_reg) ? bus.in_pixel : pair_reg;
        quad_max = (lb_rd > pair_max) ? lb_rd : pair_max;
    end

    // Raster position: column advances per accepted pixel, row advances on column wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (bus.in_valid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Row-parity state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EVEN_ROW;
        end else begin
            state <= next_state;
        end
    end

    // Flip between even and odd rows each time a row completes.
    always_comb begin
        next_state = state;
        if (bus.in_valid && col_last) begin
            next_state = (state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
        end
    end

    // On the second pixel of each pair: store to the line buffer on even rows, emit on odd rows.
    always_comb begin
        lb_we    = 1'b0;
        out_load = 1'b0;
        last_out = 1'b0;
        if (bus.in_valid && col[0]) begin
            case (state)
                EVEN_ROW: lb_we = 1'b1;
                ODD_ROW: begin
                    out_load = 1'b1;
                    last_out = row_last && col_last;
                end
                default: ;
            endcase
        end
    end

    // Hold the first pixel of each horizontal pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_reg <= '0;
        end else if (bus.in_valid && !col[0]) begin
            pair_reg <= bus.in_pixel;
        end
    end

    // Line buffer is always rewritten on an even row before the odd row reads it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf[lb_idx] <= pair_max;
        end
    end

    // Registered pooled output; the pixel value holds between valid cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.out_pixel  <= '0;
        end else begin
            bus.out_valid  <= out_load;
            bus.frame_done <= last_out;
            if (out_load) begin
                bus.out_pixel <= quad_max;
            end
        end
    end

endmodule
